seg_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment output stage for the Hamming decoder display path. It takes N_DIG digit patterns of the corrected word and N_DIG digit patterns of the error/syndrome view, and latches them with the decoder status flags on a valid strobe. It then scans the digits onto one shared segment bus with anode blanking. The source is chosen by flag priority (double > single > none > switch). On a double error the error view blinks. The switch is synchronised and debounced internally.

---
 rtl/seg_scan_mux.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment output stage for the Hamming
// decoder display. Latches word/error digit patterns and decoder flags on a
// valid strobe, picks the source by flag priority, blinks the error view on a
// double error and scans the digits onto one shared bus with anode blanking.
module seg_scan_mux #(
    parameter int N_DIG        = 4,
    parameter int SCAN_DIV     = 27000,
    parameter int BLANK_CYCLES = 270,
    parameter int BLINK_FRAMES = 250,
    parameter int DEB_CYCLES   = 270000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7*N_DIG-1:0] seg_word,
    input  logic [7*N_DIG-1:0] seg_err,
    input  logic               valid,
    input  logic               error_simple,
    input  logic               error_doble,
    input  logic               no_error,
    input  logic               swi,
    output logic [6:0]         seg_out,
    output logic [N_DIG-1:0]   an_out,
    output logic               show_err
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIG - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

    logic [7*N_DIG-1:0] word_q;
    logic [7*N_DIG-1:0] err_q;
    logic               sgl_q;
    logic               dbl_q;
    logic               nok_q;

    logic               swi_meta;
    logic               swi_sync;
    logic               swi_db;
    logic [DW-1:0]      deb_cnt;

    logic [PW-1:0]      presc;
    logic [IW-1:0]      idx;
    logic [FW-1:0]      frame_cnt;
    logic               blink_on;

    logic               slot_wrap;
    logic               frame_wrap;
    logic               dbl_next;
    logic               sel_err;
    logic               blank;
    logic [6:0]         digit_pat;
    logic [N_DIG-1:0]   an_sel;

    // Capture the digit patterns and decoder flags on the valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            err_q  <= '0;
            sgl_q  <= 1'b0;
            dbl_q  <= 1'b0;
            nok_q  <= 1'b0;
        end else if (valid) begin
            word_q <= seg_word;
            err_q  <= seg_err;
            sgl_q  <= error_simple;
            dbl_q  <= error_doble;
            nok_q  <= no_error;
        end
    end

    // Two-flop synchroniser for the asynchronous user switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swi_meta <= 1'b0;
            swi_sync <= 1'b0;
        end else begin
            swi_meta <= swi;
            swi_sync <= swi_meta;
        end
    end

    // Accept a new switch level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swi_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (swi_sync == swi_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
            swi_db  <= swi_sync;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Decode the scan wraps, the effective double flag and the selected digit
    always_comb begin
        slot_wrap  = (presc == PRESC_MAX);
        frame_wrap = slot_wrap && (idx == IDX_MAX);
        dbl_next   = valid ? error_doble : dbl_q;
        sel_err    = dbl_q | (~sgl_q & ~nok_q & swi_db);
        blank      = (presc < BLANK_END);
        digit_pat  = sel_err ? err_q[idx*7 +: 7] : word_q[idx*7 +: 7];
        an_sel     = '1;
        an_sel[idx] = 1'b0;
    end

    // Slot prescaler and digit index, advancing the digit on every slot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_wrap) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink phase: count frames while a double error is latched, else hold lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!dbl_next) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Registered segment/anode outputs with blanking at the start of each slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out  <= '0;
            an_out   <= '1;
            show_err <= 1'b0;
        end else begin
            show_err <= sel_err;
            if (blank) begin
                seg_out <= '0;
                an_out  <= '1;
            end else begin
                seg_out <= blink_on ? digit_pat : 7'b0000000;
                an_out  <= an_sel;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed testbench for seg_scan_mux with a small scan geometry.
module tb_seg_scan_mux;

    localparam int N_DIG = 4;

    logic               clk;
    logic               rst_n;
    logic [7*N_DIG-1:0] seg_word;
    logic [7*N_DIG-1:0] seg_err;
    logic               valid;
    logic               error_simple;
    logic               error_doble;
    logic               no_error;
    logic               swi;
    logic [6:0]         seg_out;
    logic [N_DIG-1:0]   an_out;
    logic               show_err;

    int total;
    int bad;
    int cyc;

    logic [27:0] word_pats;
    logic [27:0] err_pats;
    logic [27:0] hold_pats;

    seg_scan_mux #(
        .N_DIG(4),
        .SCAN_DIV(8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2),
        .DEB_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_word(seg_word),
        .seg_err(seg_err),
        .valid(valid),
        .error_simple(error_simple),
        .error_doble(error_doble),
        .no_error(no_error),
        .swi(swi),
        .seg_out(seg_out),
        .an_out(an_out),
        .show_err(show_err)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected anodes after edge c, counting edges from reset release
    function automatic logic [3:0] exp_an(int c);
        int p;
        int d;
        p = (c - 1) % 8;
        d = ((c - 1) / 8) % 4;
        if (p < 2) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    // Expected segments after edge c for a given source and blink phase
    function automatic logic [6:0] exp_seg(int c, logic [27:0] pats, bit on);
        int p;
        int d;
        p = (c - 1) % 8;
        d = ((c - 1) / 8) % 4;
        if (p < 2 || !on) return 7'b0000000;
        return pats[d*7 +: 7];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        @(negedge clk);
        total++;
        if (seg_out !== 7'b0000000) begin
            bad++;
            $display("[TB] FAIL reset_seg got=%b want=%b", seg_out, 7'b0000000);
        end
        total++;
        if (an_out !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL reset_an got=%b want=%b", an_out, 4'b1111);
        end
        total++;
        if (show_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_show got=%b want=0", show_err);
        end
    endtask

    task automatic test_scan();
        rst_n        = 1'b1;
        cyc          = 0;
        seg_word     = word_pats;
        no_error     = 1'b1;
        valid        = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            valid = 1'b0;
            total++;
            if (an_out !== exp_an(cyc)) begin
                bad++;
                $display("[TB] FAIL scan_an cyc=%0d got=%b want=%b", cyc, an_out, exp_an(cyc));
            end
            total++;
            if (seg_out !== exp_seg(cyc, word_pats, 1'b1)) begin
                bad++;
                $display("[TB] FAIL scan_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, word_pats, 1'b1));
            end
            total++;
            if (show_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL scan_show cyc=%0d got=%b want=0", cyc, show_err);
            end
        end
    endtask

    task automatic test_blink();
        bit on;
        seg_err     = err_pats;
        error_doble = 1'b1;
        no_error    = 1'b0;
        valid       = 1'b1;
        step();
        valid = 1'b0;
        while (cyc < 192) begin
            step();
            on = !(cyc >= 97 && cyc <= 160);
            total++;
            if (an_out !== exp_an(cyc)) begin
                bad++;
                $display("[TB] FAIL blink_an cyc=%0d got=%b want=%b", cyc, an_out, exp_an(cyc));
            end
            total++;
            if (seg_out !== exp_seg(cyc, err_pats, on)) begin
                bad++;
                $display("[TB] FAIL blink_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, err_pats, on));
            end
            total++;
            if (show_err !== 1'b1) begin
                bad++;
                $display("[TB] FAIL blink_show cyc=%0d got=%b want=1", cyc, show_err);
            end
        end
    endtask

    task automatic test_simple_switch();
        swi          = 1'b1;
        error_simple = 1'b1;
        error_doble  = 1'b0;
        no_error     = 1'b0;
        valid        = 1'b1;
        step();
        valid = 1'b0;
        while (cyc < 224) begin
            step();
            total++;
            if (seg_out !== exp_seg(cyc, word_pats, 1'b1)) begin
                bad++;
                $display("[TB] FAIL single_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, word_pats, 1'b1));
            end
            total++;
            if (show_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL single_show cyc=%0d got=%b want=0", cyc, show_err);
            end
        end
        error_simple = 1'b0;
        valid        = 1'b1;
        step();
        valid = 1'b0;
        total++;
        if (show_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL noflag_show_early cyc=%0d got=%b want=0", cyc, show_err);
        end
        while (cyc < 240) begin
            step();
            total++;
            if (show_err !== 1'b1) begin
                bad++;
                $display("[TB] FAIL noflag_show cyc=%0d got=%b want=1", cyc, show_err);
            end
            total++;
            if (seg_out !== exp_seg(cyc, err_pats, 1'b1)) begin
                bad++;
                $display("[TB] FAIL noflag_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, err_pats, 1'b1));
            end
        end
    endtask

    task automatic test_glitch();
        swi = 1'b0;
        for (int k = 0; k < 10; k++) step();
        total++;
        if (show_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL swi_low_show cyc=%0d got=%b want=0", cyc, show_err);
        end
        swi = 1'b1;
        for (int k = 0; k < 3; k++) step();
        swi = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (show_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL glitch_show cyc=%0d got=%b want=0", cyc, show_err);
            end
            total++;
            if (seg_out !== exp_seg(cyc, word_pats, 1'b1)) begin
                bad++;
                $display("[TB] FAIL glitch_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, word_pats, 1'b1));
            end
        end
        swi = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (show_err !== (i >= 7)) begin
                bad++;
                $display("[TB] FAIL deb_show step=%0d got=%b want=%b", i, show_err, (i >= 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        swi = 1'b0;
        while (((cyc - 1) % 32) != 20) step();
        total++;
        if (an_out !== 4'b1011) begin
            bad++;
            $display("[TB] FAIL mid_an_before got=%b want=%b", an_out, 4'b1011);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (an_out !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL mid_reset_an got=%b want=%b", an_out, 4'b1111);
        end
        total++;
        if (seg_out !== 7'b0000000) begin
            bad++;
            $display("[TB] FAIL mid_reset_seg got=%h want=00", seg_out);
        end
        total++;
        if (show_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_show got=%b want=0", show_err);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (an_out !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL mid_hold_an got=%b want=%b", an_out, 4'b1111);
        end
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (an_out !== exp_an(cyc)) begin
                bad++;
                $display("[TB] FAIL restart_an cyc=%0d got=%b want=%b", cyc, an_out, exp_an(cyc));
            end
            total++;
            if (seg_out !== 7'b0000000) begin
                bad++;
                $display("[TB] FAIL restart_seg cyc=%0d got=%h want=00", cyc, seg_out);
            end
            total++;
            if (show_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL restart_show cyc=%0d got=%b want=0", cyc, show_err);
            end
        end
    endtask

    task automatic test_hold();
        seg_word = hold_pats;
        no_error = 1'b1;
        valid    = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            seg_word = 28'($urandom);
            step();
            total++;
            if (seg_out !== exp_seg(cyc, hold_pats, 1'b1)) begin
                bad++;
                $display("[TB] FAIL hold_seg cyc=%0d got=%h want=%h", cyc, seg_out, exp_seg(cyc, hold_pats, 1'b1));
            end
            total++;
            if (an_out !== exp_an(cyc)) begin
                bad++;
                $display("[TB] FAIL hold_an cyc=%0d got=%b want=%b", cyc, an_out, exp_an(cyc));
            end
        end
    endtask

    // Run every scenario in order, then print the summary
    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        word_pats    = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        err_pats     = {4{7'h79}};
        hold_pats    = {7'h07, 7'h7D, 7'h6D, 7'h66};
        rst_n        = 1'b0;
        seg_word     = '0;
        seg_err      = '0;
        valid        = 1'b0;
        error_simple = 1'b0;
        error_doble  = 1'b0;
        no_error     = 1'b0;
        swi          = 1'b0;
        $display("[TB] starting seg_scan_mux bench");
        test_reset();
        test_scan();
        test_blink();
        test_simple_switch();
        test_glitch();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
